// File: rtl/modn_sequencer_if.sv
// modn_sequencer_if: control inputs and decoded outputs of one modulo-N sequencer stage.
// Stage-to-stage cascading goes through the tc/_ce pair outside the interface.
interface modn_sequencer_if #(
  parameter int unsigned N = 10,
  parameter int unsigned W = $clog2(N)
);
  logic         _ce;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] cnt;
  logic [N-1:0] q;
  logic         _co;
  logic         tc;

  modport master (
    output _ce, up, load, d,
    input  cnt, q, _co, tc
  );

  modport slave (
    input  _ce, up, load, d,
    output cnt, q, _co, tc
  );
endinterface

// File: rtl/modn_sequencer.sv
// modn_sequencer: synchronous modulo-N one-hot sequencer (4017-style decade counter, generalised).
// Binary index cnt, one-hot decode q, split carry _co, combinational terminal count tc.
// Optional feature macro MODN_SEQUENCER_ONESHOT_EN: when defined, counting stops at the
// terminal state (N-1 going up, 0 going down) instead of wrapping.
module modn_sequencer #(
  parameter int unsigned N        = 10,
  parameter int unsigned CO_SPLIT = N / 2,
  parameter int unsigned W        = $clog2(N),
  parameter int unsigned LOG      = 0
) (
  input logic             cp,
  input logic             mr,
  modn_sequencer_if.slave bus
);

  localparam logic [W-1:0] CNT_MAX = W'(N - 1);
  localparam logic [W-1:0] CO_LIM  = W'(CO_SPLIT);
  localparam logic [W:0]   N_EXT   = (W + 1)'(N);

`ifdef MODN_SEQUENCER_ONESHOT_EN
  localparam logic ONESHOT = 1'b1;
`else
  localparam logic ONESHOT = 1'b0;
`endif

  if (N < 2 || N > 256) begin : g_bad_n
    $error("modn_sequencer: N=%0d outside legal range 2..256", N);
  end
  if (CO_SPLIT < 1 || CO_SPLIT > N - 1) begin : g_bad_co
    $error("modn_sequencer: CO_SPLIT=%0d outside legal range 1..N-1", CO_SPLIT);
  end
  if (W != $clog2(N)) begin : g_bad_w
    $error("modn_sequencer: W is derived from N and must not be overridden");
  end
  if (LOG > 1) begin : g_bad_log
    $error("modn_sequencer: LOG must be 0 or 1");
  end

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_next;
  logic         at_max;
  logic         at_min;
  logic         load_ok;

  // Terminal detection uses explicit compares so non-power-of-2 N never relies on 2^W overflow.
  assign at_max  = (cnt_q == CNT_MAX);
  assign at_min  = (cnt_q == '0);
  assign load_ok = ({1'b0, bus.d} < N_EXT);

  // Index register: reset dominates everything else.
  always_ff @(posedge cp) begin
    if (mr) cnt_q <= '0;
    else    cnt_q <= cnt_next;
  end

  // Next index: load beats count, count beats hold; out-of-range load values land on 0.
  always_comb begin
    cnt_next = cnt_q;
    if (bus.load) begin
      cnt_next = load_ok ? bus.d : '0;
    end else if (!bus._ce) begin
      if (bus.up) cnt_next = at_max ? (ONESHOT ? cnt_q : '0) : cnt_q + W'(1);
      else        cnt_next = at_min ? (ONESHOT ? cnt_q : CNT_MAX) : cnt_q - W'(1);
    end
  end

  // Outputs: pure decode of the registered index plus combinational terminal count.
  always_comb begin
    bus.cnt = cnt_q;
    bus.q   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bus.q[i] = (cnt_q == W'(i));
    end
    bus._co = (cnt_q < CO_LIM);
    bus.tc  = !bus._ce && ((bus.up && at_max) || (!bus.up && at_min));
  end

endmodule
